axi_lite_regbank: RTL and testbench
===================================

Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank that replaces the fixed-handshake wrapper slave. It implements full AXI4-Lite handshakes with backpressure, independent AW/W acceptance, WSTRB byte enables and SLVERR on unmapped addresses. It provides NUM_CTRL read/write control registers, a raw status register, and sticky edge-triggered interrupt status with an enable mask and a registered IRQ line. It sits between the PS AXI interconnect and the user core.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2^ADDR >= 16 + 4*NUM_CTRL.
NUM_CTRL, 4, number of RW control registers (1..12).
NUM_STATUS, 3, number of status/interrupt input bits (1..32).
ID_VALUE, 32'h1D0C_0002, value of the read-only ID register.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
ctrl_out  out  32*NUM_CTRL  control registers, flattened; CTRL[k] = bits [32k+31:32k]
status_in  in  NUM_STATUS  live status from core (e.g. granted, denied, flag); synchronous to ACLK
irq  out  1  level interrupt = |(IRQ_STATUS & IRQ_ENABLE), registered

Behaviour:
- Reset (async assert, sync deassert by system): all READY=1 except BVALID=0, RVALID=0, RDATA=0, BRESP/RRESP=00, ctrl_out=0, IRQ_STATUS=0, IRQ_ENABLE=0, irq=0, status edge history=0.
- Register map (word index = addr[ADDR-1:2]):
  - 0x00 ID: RO.
  - 0x04 IRQ_STATUS: W1C, bit i sets on a 0->1 edge of status_in[i].
  - 0x08 IRQ_ENABLE: RW, width NUM_STATUS.
  - 0x0C STATUS: RO raw status_in, zero-extended.
  - 0x10+4k CTRL[k]: RW.
  - Any other address: unmapped.
- Write path:
  - AW and W are captured independently into holding registers. AWREADY drops after AW capture; WREADY drops after W capture.
  - Commit occurs in the cycle both are held and BVALID=0. BVALID rises the next cycle. Both holds clear and READY re-asserts on commit.
  - BVALID is held until BREADY. While BVALID && !BREADY, no new commit occurs; one AW and one W may still be captured.
  - Writes to RO or unmapped addresses: no state change, BRESP=SLVERR (10). Otherwise OKAY.
  - WSTRB applies per byte to CTRL and IRQ_ENABLE. For IRQ_STATUS, a bit clears only when its byte strobe and data bit are both 1.
- Read path:
  - ARREADY = !RVALID || RREADY.
  - On AR handshake, RDATA/RRESP are registered and RVALID=1 the next cycle (latency 1).
  - RDATA and RRESP are held stable until RREADY. Back-to-back reads sustain 1 read per cycle with RREADY=1.
  - Unmapped reads: RDATA=32'hDEADDEAD, RRESP=SLVERR.
- Simultaneous events:
  - An edge on status bit i and a W1C of bit i in the same cycle: set wins, bit stays 1.
  - A read and a write commit to the same register in the same cycle: the read returns the pre-write value.
- irq updates one cycle after IRQ_STATUS/IRQ_ENABLE changes.
- Reset asserted mid-transaction: all pending AW/W/B/R state is discarded immediately; no response is issued for it.

Decomposition:
- Package axi_lite_regbank_pkg holds:
  - RESP_OKAY/RESP_SLVERR
  - register offsets ADDR_ID, ADDR_IRQ_STATUS, ADDR_IRQ_ENABLE, ADDR_STATUS, ADDR_CTRL_BASE
  - DEAD_PATTERN
- Sub-module irq_sticky_bank (params NUM_STATUS) holds:
  - the edge detector
  - sticky IRQ_STATUS with W1C and set-wins priority
  - IRQ_ENABLE masking
  - registered irq output
- The top module holds the AXI channel logic and the CTRL registers.

Test Plan:
1. Reset, then read 0x00, 0x0C with status_in=3'b101 -> RDATA=ID_VALUE then 32'h5, RRESP=00, each RVALID 1 cycle after AR handshake.
2. Write 0x14 data 32'hA5A5_1234 WSTRB=4'b0011, W presented 3 cycles before AW -> WREADY low after capture, single BVALID OKAY, ctrl_out CTRL[1]=32'h0000_1234.
3. Hold BREADY=0 for 5 cycles after a write, issue a second write -> BVALID stays high, second commit only after first B handshake, two OKAY responses in order.
4. Enable 0x08=3'b111, pulse status_in[1] -> IRQ_STATUS=32'h2, irq=1. Write 0x04 data 2 in the same cycle as a new status_in[1] edge -> bit stays set. A later clean W1C clears it -> irq=0 next cycle.
5. Read 0x3C and write 0x00 -> RDATA=32'hDEADDEAD RRESP=10. BRESP=10 with ID unchanged.
6. Assert ARESETN low while BVALID=1 and RVALID=1 with RREADY=0 -> both drop immediately, ctrl_out=0, no response after release.

Source files
------------

// File: rtl/axi_lite_regbank_pkg.sv
// Shared constants for the AXI4-Lite register bank: response codes,
// register byte offsets and the fill pattern returned for unmapped reads.
package axi_lite_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned ADDR_ID         = 32'h00;
    localparam int unsigned ADDR_IRQ_STATUS = 32'h04;
    localparam int unsigned ADDR_IRQ_ENABLE = 32'h08;
    localparam int unsigned ADDR_STATUS     = 32'h0C;
    localparam int unsigned ADDR_CTRL_BASE  = 32'h10;

    localparam logic [31:0] DEAD_PATTERN = 32'hDEAD_DEAD;

endpackage

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register bank (slave).
interface axi_lite_regbank_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_lite_regbank_irq_sticky_bank.sv
// Sticky rising-edge interrupt status with write-one-to-clear, an enable mask
// and a registered level IRQ output.
module irq_sticky_bank #(
    parameter int NUM_STATUS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_STATUS-1:0] i_status,
    input  logic [NUM_STATUS-1:0] i_wdata,
    input  logic [NUM_STATUS-1:0] i_bmask,
    input  logic                  i_isr_we,
    input  logic                  i_ien_we,
    output logic [NUM_STATUS-1:0] o_irq_status,
    output logic [NUM_STATUS-1:0] o_irq_enable,
    output logic                  o_irq
);

    logic [NUM_STATUS-1:0] r_prev;
    logic [NUM_STATUS-1:0] r_isr;
    logic [NUM_STATUS-1:0] r_ien;
    logic                  r_irq;
    logic [NUM_STATUS-1:0] w_edge;
    logic [NUM_STATUS-1:0] w_clr;

    assign w_edge = i_status & ~r_prev;
    assign w_clr  = i_isr_we ? (i_wdata & i_bmask) : '0;

    // Clear is applied before set so a coincident edge keeps the bit high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
            r_isr  <= '0;
            r_ien  <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= i_status;
            r_isr  <= (r_isr & ~w_clr) | w_edge;
            if (i_ien_we) begin
                r_ien <= (r_ien & ~i_bmask) | (i_wdata & i_bmask);
            end
            r_irq <= |(r_isr & r_ien);
        end
    end

    assign o_irq_status = r_isr;
    assign o_irq_enable = r_ien;
    assign o_irq        = r_irq;

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: ID, sticky IRQ status/enable, raw status and
// NUM_CTRL byte-writable control registers, with independent AW/W capture.
module axi_lite_regbank
    import axi_lite_regbank_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          NUM_CTRL           = 4,
    parameter int          NUM_STATUS         = 3,
    parameter logic [31:0] ID_VALUE           = 32'h1D0C_0002
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    axi_lite_regbank_if.slave       s_axi,
    output logic [32*NUM_CTRL-1:0]  ctrl_out,
    input  logic [NUM_STATUS-1:0]   status_in,
    output logic                    irq
);

    localparam int WIDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [WIDX_W-1:0] IDX_ID  = WIDX_W'(ADDR_ID >> 2);
    localparam logic [WIDX_W-1:0] IDX_ISR = WIDX_W'(ADDR_IRQ_STATUS >> 2);
    localparam logic [WIDX_W-1:0] IDX_IEN = WIDX_W'(ADDR_IRQ_ENABLE >> 2);
    localparam logic [WIDX_W-1:0] IDX_STS = WIDX_W'(ADDR_STATUS >> 2);
    localparam int unsigned CTRL_IDX0 = ADDR_CTRL_BASE >> 2;

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axi_lite_regbank supports only 32-bit data");
    end

    logic                  r_aw_held;
    logic [WIDX_W-1:0]     r_aw_idx;
    logic                  r_w_held;
    logic [31:0]           r_w_data;
    logic [3:0]            r_w_strb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_commit;
    logic                  w_wr_ok;
    logic [NUM_CTRL-1:0]   w_wr_ctrl_hit;
    logic [NUM_CTRL-1:0]   w_rd_ctrl_hit;
    logic [WIDX_W-1:0]     w_rd_idx;
    logic                  w_arready;
    logic [31:0]           w_rd_data;
    logic [1:0]            w_rd_resp;
    logic [NUM_STATUS-1:0] w_bmask;
    logic [NUM_STATUS-1:0] w_irq_status;
    logic [NUM_STATUS-1:0] w_irq_enable;
    logic                  w_unused;

    assign w_unused = ^{s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

    assign s_axi.AWREADY = !r_aw_held;
    assign s_axi.WREADY  = !r_w_held;
    assign s_axi.BVALID  = r_bvalid;
    assign s_axi.BRESP   = r_bresp;
    assign s_axi.RVALID  = r_rvalid;
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;

    assign w_arready     = !r_rvalid || s_axi.RREADY;
    assign s_axi.ARREADY = w_arready;
    assign w_rd_idx      = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    // A pending response blocks the commit; the held AW/W simply wait.
    assign w_commit = r_aw_held && r_w_held && !r_bvalid;
    assign w_wr_ok  = (r_aw_idx == IDX_ISR) || (r_aw_idx == IDX_IEN) || (|w_wr_ctrl_hit);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (s_axi.AWVALID && !r_aw_held) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (s_axi.WVALID && !r_w_held) begin
                r_w_held <= 1'b1;
                r_w_data <= s_axi.WDATA;
                r_w_strb <= s_axi.WSTRB;
            end
            if (r_bvalid && s_axi.BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
        logic [31:0] r_val;

        assign w_wr_ctrl_hit[gi] = (r_aw_idx == WIDX_W'(CTRL_IDX0 + gi));
        assign w_rd_ctrl_hit[gi] = (w_rd_idx == WIDX_W'(CTRL_IDX0 + gi));

        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                r_val <= '0;
            end else if (w_commit && w_wr_ctrl_hit[gi]) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_w_strb[b]) r_val[8*b +: 8] <= r_w_data[8*b +: 8];
                end
            end
        end

        assign ctrl_out[32*gi +: 32] = r_val;
    end

    for (gi = 0; gi < NUM_STATUS; gi++) begin : g_bmask
        assign w_bmask[gi] = r_w_strb[gi/8];
    end

    irq_sticky_bank #(.NUM_STATUS(NUM_STATUS)) u_irq (
        .i_clk        (S_AXI_ACLK),
        .i_rst_n      (S_AXI_ARESETN),
        .i_status     (status_in),
        .i_wdata      (r_w_data[NUM_STATUS-1:0]),
        .i_bmask      (w_bmask),
        .i_isr_we     (w_commit && (r_aw_idx == IDX_ISR)),
        .i_ien_we     (w_commit && (r_aw_idx == IDX_IEN)),
        .o_irq_status (w_irq_status),
        .o_irq_enable (w_irq_enable),
        .o_irq        (irq)
    );

    // Read mux samples current register contents, so a same-cycle commit is not visible.
    always_comb begin
        w_rd_data = DEAD_PATTERN;
        w_rd_resp = RESP_SLVERR;
        if (w_rd_idx == IDX_ID) begin
            w_rd_data = ID_VALUE;
            w_rd_resp = RESP_OKAY;
        end else if (w_rd_idx == IDX_ISR) begin
            w_rd_data = 32'(w_irq_status);
            w_rd_resp = RESP_OKAY;
        end else if (w_rd_idx == IDX_IEN) begin
            w_rd_data = 32'(w_irq_enable);
            w_rd_resp = RESP_OKAY;
        end else if (w_rd_idx == IDX_STS) begin
            w_rd_data = 32'(status_in);
            w_rd_resp = RESP_OKAY;
        end else if (|w_rd_ctrl_hit) begin
            w_rd_resp = RESP_OKAY;
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (w_rd_ctrl_hit[k]) w_rd_data = ctrl_out[32*k +: 32];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (s_axi.ARVALID && w_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (s_axi.RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed plus randomized bench for axi_lite_regbank against a register-map model.
`timescale 1ns/1ps
module tb_axi_lite_regbank;

    localparam int          AW  = 6;
    localparam int          NC  = 4;
    localparam int          NS  = 3;
    localparam logic [31:0] IDV = 32'h1D0C_0002;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [32*NC-1:0]     ctrl_out;
    logic [NS-1:0]        status_in;
    logic                 irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]   m_ctrl [NC];
    logic [NS-1:0] m_isr, m_ien, m_prev;

    axi_lite_regbank_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    axi_lite_regbank #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_CTRL(NC), .NUM_STATUS(NS), .ID_VALUE(IDV)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus),
        .ctrl_out      (ctrl_out),
        .status_in     (status_in),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) m_ctrl[k] = '0;
        m_isr = '0; m_ien = '0; m_prev = '0;
    endtask

    // Status is driven just after an edge; the DUT samples it at the next edge.
    task automatic set_status_now(input logic [NS-1:0] v);
        status_in = v;
        m_isr     = m_isr | (v & ~m_prev);
        m_prev    = v;
    endtask

    function automatic void exp_read(input int w, output logic [31:0] d, output logic [1:0] r);
        r = 2'b00;
        case (w)
            0: d = IDV;
            1: d = 32'(m_isr);
            2: d = 32'(m_ien);
            3: d = 32'(status_in);
            default: begin
                if (w >= 4 && w < 4 + NC) d = m_ctrl[w-4];
                else begin d = 32'hDEAD_DEAD; r = 2'b10; end
            end
        endcase
    endfunction

    function automatic logic [1:0] model_write(input int w, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] bm;
        for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{strb[b]}};
        if (w == 1) begin
            m_isr = m_isr & ~NS'(data & bm);
            return 2'b00;
        end else if (w == 2) begin
            m_ien = (m_ien & ~NS'(bm)) | NS'(data & bm);
            return 2'b00;
        end else if (w >= 4 && w < 4 + NC) begin
            m_ctrl[w-4] = (m_ctrl[w-4] & ~bm) | (data & bm);
            return 2'b00;
        end
        return 2'b10;
    endfunction

    task automatic chk_ctrl();
        for (int k = 0; k < NC; k++) chk($sformatf("ctrl_out[%0d]", k), ctrl_out[32*k +: 32], m_ctrl[k]);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input bit st_chg, input logic [NS-1:0] st_val);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        logic [1:0] exp_resp;
        bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
        if (w_lead == 0) begin bus.AWADDR = addr; bus.AWVALID = 1'b1; end
        while (!(aw_done && w_done) && cyc < 40) begin
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            tick(); cyc++;
            if (aw_hs) begin bus.AWVALID = 1'b0; aw_done = 1; end
            if (w_hs)  begin bus.WVALID  = 1'b0; w_done  = 1; end
            if (w_done && !aw_done) chk("wready_low_after_w_capture", 32'(bus.WREADY), 32'd0);
            if (!aw_done && !bus.AWVALID && cyc >= w_lead) begin bus.AWADDR = addr; bus.AWVALID = 1'b1; end
        end
        chk("write_handshakes_done", 32'(aw_done && w_done), 32'd1);
        exp_resp = model_write(int'(addr[AW-1:2]), data, strb);
        if (st_chg) set_status_now(st_val);
        cyc = 0;
        while (!bus.BVALID && cyc < 40) begin tick(); cyc++; end
        chk("bvalid_latency", 32'(cyc), 32'd1);
        chk($sformatf("bresp@%h", addr), 32'(bus.BRESP), 32'(exp_resp));
        tick();
        chk("bvalid_single", 32'(bus.BVALID), 32'd0);
        bus.BREADY = 1'b0;
    endtask

    task automatic check_read(input logic [AW-1:0] addr);
        logic [31:0] ed; logic [1:0] er; int cyc = 0;
        exp_read(int'(addr[AW-1:2]), ed, er);
        bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        while (!(bus.ARVALID && bus.ARREADY) && cyc < 40) begin tick(); cyc++; end
        tick();
        bus.ARVALID = 1'b0;
        chk("rvalid_latency", 32'(bus.RVALID), 32'd1);
        chk($sformatf("rdata@%h", addr), bus.RDATA, ed);
        chk($sformatf("rresp@%h", addr), 32'(bus.RRESP), 32'(er));
        tick();
        chk("rvalid_drop", 32'(bus.RVALID), 32'd0);
        bus.RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] ed, d1, d2;
        logic [1:0]  er;
        int          w;

        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        status_in = 3'b101;
        model_reset();
        repeat (3) tick();

        chk("rst_awready", 32'(bus.AWREADY), 32'd1);
        chk("rst_wready", 32'(bus.WREADY), 32'd1);
        chk("rst_arready", 32'(bus.ARREADY), 32'd1);
        chk("rst_bvalid", 32'(bus.BVALID), 32'd0);
        chk("rst_rvalid", 32'(bus.RVALID), 32'd0);
        chk("rst_rdata", bus.RDATA, 32'd0);
        chk("rst_bresp", 32'(bus.BRESP), 32'd0);
        chk("rst_rresp", 32'(bus.RRESP), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk_ctrl();

        rst_n = 1'b1;
        set_status_now(3'b101);
        tick();

        // ID and raw status, then sticky bits latched from the post-reset edges.
        check_read(6'h00);
        check_read(6'h0C);
        check_read(6'h04);

        // Partial-strobe write with W leading AW by three cycles.
        do_write(6'h14, 32'hA5A5_1234, 4'b0011, 3, 1'b0, '0);
        chk_ctrl();
        check_read(6'h14);

        // Response backpressure: second write is captured but not committed.
        d1 = $urandom; d2 = $urandom;
        bus.BREADY = 1'b0;
        bus.AWADDR = 6'h18; bus.AWVALID = 1'b1; bus.WDATA = d1; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        tick();
        chk("bp_first_bvalid", 32'(bus.BVALID), 32'd1);
        chk("bp_first_bresp", 32'(bus.BRESP), 32'(model_write(6, d1, 4'hF)));
        chk_ctrl();
        bus.AWADDR = 6'h1C; bus.AWVALID = 1'b1; bus.WDATA = d2; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        chk("bp_awready_held", 32'(bus.AWREADY), 32'd0);
        chk("bp_wready_held", 32'(bus.WREADY), 32'd0);
        repeat (3) begin
            tick();
            chk("bp_bvalid_hold", 32'(bus.BVALID), 32'd1);
            chk("bp_no_second_commit", ctrl_out[32*3 +: 32], m_ctrl[3]);
        end
        bus.BREADY = 1'b1;
        tick();
        chk("bp_bvalid_after_hs", 32'(bus.BVALID), 32'd0);
        chk("bp_commit_waits", ctrl_out[32*3 +: 32], m_ctrl[3]);
        tick();
        chk("bp_second_bvalid", 32'(bus.BVALID), 32'd1);
        chk("bp_second_bresp", 32'(bus.BRESP), 32'(model_write(7, d2, 4'hF)));
        chk_ctrl();
        tick();
        chk("bp_second_single", 32'(bus.BVALID), 32'd0);
        bus.BREADY = 1'b0;

        // Unmapped read and read-only write.
        check_read(6'h3C);
        do_write(6'h00, $urandom, 4'hF, 0, 1'b0, '0);
        check_read(6'h00);

        // Back-to-back reads at one per cycle.
        bus.RREADY = 1'b1; bus.ARVALID = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(0, 15);
            bus.ARADDR = {w[3:0], 2'b00};
            exp_read(w, ed, er);
            chk("burst_arready", 32'(bus.ARREADY), 32'd1);
            tick();
            chk("burst_rvalid", 32'(bus.RVALID), 32'd1);
            chk($sformatf("burst_rdata[%0d]", i), bus.RDATA, ed);
            chk($sformatf("burst_rresp[%0d]", i), 32'(bus.RRESP), 32'(er));
        end
        bus.ARVALID = 1'b0;
        tick();
        bus.RREADY = 1'b0;

        // Randomized mix of reads and writes across the whole address space.
        for (int i = 0; i < 30; i++) begin
            w = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                do_write({w[3:0], 2'b00}, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b0, '0);
                chk_ctrl();
            end else begin
                check_read({w[3:0], 2'b00});
            end
            chk("rand_irq", 32'(irq), 32'(|(m_isr & m_ien)));
        end

        // Interrupt: edge latch, registered irq, set-wins against W1C, clean clear.
        set_status_now(3'b000);
        tick();
        do_write(6'h04, 32'h7, 4'hF, 0, 1'b0, '0);
        do_write(6'h08, 32'h7, 4'h1, 0, 1'b0, '0);
        check_read(6'h04);
        set_status_now(3'b010);
        tick();
        chk("irq_lags_status", 32'(irq), 32'd0);
        tick();
        chk("irq_set", 32'(irq), 32'd1);
        check_read(6'h04);
        set_status_now(3'b000);
        tick();
        do_write(6'h04, 32'h2, 4'hF, 0, 1'b1, 3'b010);
        check_read(6'h04);
        chk("irq_set_wins", 32'(irq), 32'd1);
        set_status_now(3'b000);
        tick();
        do_write(6'h04, 32'h2, 4'hF, 0, 1'b0, '0);
        check_read(6'h04);
        chk("irq_cleared", 32'(irq), 32'd0);

        // Reset with a write response and a read response both outstanding.
        do_write(6'h10, 32'hCAFE_F00D, 4'hF, 0, 1'b0, '0);
        bus.BREADY = 1'b0;
        bus.AWADDR = 6'h10; bus.AWVALID = 1'b1; bus.WDATA = 32'h1111_2222; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        tick();
        bus.ARADDR = 6'h00; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        tick();
        bus.ARVALID = 1'b0;
        chk("pre_rst_bvalid", 32'(bus.BVALID), 32'd1);
        chk("pre_rst_rvalid", 32'(bus.RVALID), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_bvalid", 32'(bus.BVALID), 32'd0);
        chk("async_rst_rvalid", 32'(bus.RVALID), 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk_ctrl();
        tick();
        rst_n = 1'b1;
        set_status_now(status_in);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        repeat (5) begin
            tick();
            chk("post_rst_no_b", 32'(bus.BVALID), 32'd0);
            chk("post_rst_no_r", 32'(bus.RVALID), 32'd0);
        end
        chk_ctrl();
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
